decode_stage: RTL
=================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32: register/datapath width; legal values 32 and 64.
REQ-002 SHALL have parameter RA_W, default 3: register address width; legal values 3 and 4. Addresses are instruction fields zero-extended to RA_W.
REQ-003 SHALL have parameter HALT_STICKY, default 1: 1 = halt holds until reset; 0 = halt clears on resume.
REQ-004 SHALL use one clock; reset is asynchronous and active-low. Ports: clk (in, 1) system clock; rst_n (in, 1) asynchronous active-low reset.
REQ-005 SHALL have these input ports:
- in_valid (in, 1): instruction present.
- instr (in, 32): instruction word.
- out_ready (in, 1): downstream accepts.
- resume (in, 1): leave HALTED when HALT_STICKY=0.
REQ-006 SHALL have these output ports:
- in_ready (out, 1).
- out_valid (out, 1).
- rd_addr1, rd_addr2, wr_addr (out, RA_W each).
- alu_op (out, 3).
- imm (out, DATA_W): instr[15:0] zero-extended.
- ctl (out, 12): one-hot-ish controls {wr_en, flag_en, alu_en, imm_sel, mem_rd, mem_wr, mov_lo, mov_hi, clr, set, shl, shr}.
- cond (out, 4): instr[24:21].
- is_bcond (out, 1).
- illegal (out, 1).
- halted (out, 1).

Function
REQ-007 SHALL decode op = instr[31:25]; every output not named for an opcode SHALL be 0.
REQ-008 LOAD 1000000 SHALL give: rd_addr1=instr[21:19], wr_addr=instr[24:22], wr_en, imm_sel, mem_rd.
REQ-009 STOR 1000001 SHALL give: rd_addr1=instr[21:19], rd_addr2=instr[24:22], imm_sel, mem_wr.
REQ-010 MOV 0000000 and MOVT 0000001 SHALL give: rd_addr1=wr_addr=instr[24:22], wr_en, imm_sel. MOV additionally sets mov_lo; MOVT additionally sets mov_hi.
REQ-011 CLR 0000010 and SET 0000011 SHALL give: wr_addr=instr[24:22], wr_en. CLR additionally sets clr; SET additionally sets set.
REQ-012 LSL 0000100 and LSR 0000101 SHALL give: rd_addr1=instr[21:19] (shift amount), wr_addr=instr[24:22], wr_en, imm_sel. LSL additionally sets shl; LSR additionally sets shr.
REQ-013 Immediate ALU ops 001S ooo, with ooo in 001..101, SHALL give: alu_op=ooo, rd_addr1=instr[21:19], wr_addr=instr[24:22], wr_en, alu_en, imm_sel, flag_en=S.
REQ-014 Register ALU ops 011S ooo, with ooo in 001..101, SHALL decode as REQ-013 but with imm_sel=0 and rd_addr2=instr[18:16].
REQ-015 NOT 0110110 SHALL decode as a register ALU op with alu_op=110 and flag_en=1.
REQ-016 Bcond 1100001 SHALL set is_bcond. NOP 1100100 SHALL assert no controls.
REQ-017 HALT 1101000 SHALL produce a NOP output word and move the FSM to HALTED.
REQ-018 Every other op, including B 1100000 and BR 1100010, SHALL set illegal=1 with all ctl=0.
REQ-019 Outputs SHALL be registered: a valid instruction accepted at edge N is presented with out_valid=1 after edge N (latency 1).
REQ-020 Handshake: transfer in when in_valid&in_ready; transfer out when out_valid&out_ready. Outputs SHALL hold stable while out_valid&!out_ready.
REQ-021 in_ready SHALL equal (state==RUN)&(!out_valid|out_ready), giving full throughput with no bubbles.
REQ-022 FSM states SHALL be RUN and HALTED:
- RUN -> HALTED on acceptance of HALT.
- HALTED -> RUN on resume=1 only when HALT_STICKY=0; resume SHALL be ignored when HALT_STICKY=1.
- In HALTED: in_ready=0 and halted=1. The HALT output word SHALL still drain normally.
REQ-023 Simultaneous out transfer and in transfer SHALL replace the output register in the same cycle, with no loss and no duplicate.
REQ-024 in_valid while in_ready=0 SHALL have no effect; the instruction is not captured.

Reset
REQ-025 While rst_n=0, SHALL be asynchronously: state=RUN, out_valid=0, all decoded outputs 0, illegal=0, halted=0, in_ready=1 once rst_n=1.
REQ-026 Reset asserted mid-stall SHALL discard the held word; no out transfer occurs after deassertion until a new input is accepted.

Verification
REQ-027 Bench SHALL cover:
- instr=0x2248_0005 (ADD r1,r1? imm=5), in_valid=1, out_ready=1 -> next cycle: out_valid=1, alu_op=001, wr_en=1, imm_sel=1, imm=5, flag_en=0.
- Back-to-back ADDS2 then SUB with out_ready=1 -> two consecutive out_valid cycles; second word has imm_sel=1, alu_op=010.
- out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 after first capture; outputs constant; no instruction lost when out_ready returns to 1.
- HALT (op 1101000) accepted -> halted=1, in_ready=0 permanently (HALT_STICKY=1). Repeat with HALT_STICKY=0 and resume pulse -> in_ready=1 the next cycle.
- op 1100000 (B) -> illegal=1, ctl=0. op 0000100 with DATA_W=64 -> shl=1, imm zero-extended to 64 bits.
- rst_n low mid-stall -> out_valid=0 immediately (asynchronous), state RUN after release.

Source files
------------

// File: rtl/decode_stage.sv
// Single-entry decode stage: turns a 32-bit instruction into register addresses,
// an immediate and control strobes behind a valid/ready output register.
module decode_stage #(
    parameter int DATA_W      = 32,
    parameter int RA_W        = 3,
    parameter int HALT_STICKY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [31:0]       instr,
    input  logic              out_ready,
    input  logic              resume,
    output logic              in_ready,
    output logic              out_valid,
    output logic [RA_W-1:0]   rd_addr1,
    output logic [RA_W-1:0]   rd_addr2,
    output logic [RA_W-1:0]   wr_addr,
    output logic [2:0]        alu_op,
    output logic [DATA_W-1:0] imm,
    output logic [11:0]       ctl,
    output logic [3:0]        cond,
    output logic              is_bcond,
    output logic              illegal,
    output logic              halted
);

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_HALTED = 1'b1;

    localparam int C_WR = 11;
    localparam int C_FL = 10;
    localparam int C_AL = 9;
    localparam int C_IS = 8;
    localparam int C_MR = 7;
    localparam int C_MW = 6;
    localparam int C_ML = 5;
    localparam int C_MH = 4;
    localparam int C_CL = 3;
    localparam int C_ST = 2;
    localparam int C_SL = 1;
    localparam int C_SR = 0;

    localparam logic [6:0] OP_HALT = 7'b1101000;

    logic [6:0]        op;
    logic [2:0]        fld_a;
    logic [2:0]        fld_b;
    logic [2:0]        fld_c;

    logic [RA_W-1:0]   rd1_d, rd2_d, wr_d;
    logic [2:0]        alu_d;
    logic [DATA_W-1:0] imm_d;
    logic [11:0]       ctl_d;
    logic [3:0]        cond_d;
    logic              bcond_d;
    logic              illegal_d;

    logic [RA_W-1:0]   rd1_q, rd2_q, wr_q;
    logic [2:0]        alu_q;
    logic [DATA_W-1:0] imm_q;
    logic [11:0]       ctl_q;
    logic [3:0]        cond_q;
    logic              bcond_q;
    logic              illegal_q;

    logic [0:0]        state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic              accept;

    assign op    = instr[31:25];
    assign fld_a = instr[24:22];
    assign fld_b = instr[21:19];
    assign fld_c = instr[18:16];

    always_comb begin
        rd1_d       = '0;
        rd2_d       = '0;
        wr_d        = '0;
        alu_d       = '0;
        ctl_d       = '0;
        bcond_d     = 1'b0;
        illegal_d   = 1'b0;
        imm_d       = '0;
        imm_d[15:0] = instr[15:0];
        cond_d      = instr[24:21];
        casez (op)
            7'b1000000: begin
                rd1_d[2:0]  = fld_b;
                wr_d[2:0]   = fld_a;
                ctl_d[C_WR] = 1'b1;
                ctl_d[C_IS] = 1'b1;
                ctl_d[C_MR] = 1'b1;
            end
            7'b1000001: begin
                rd1_d[2:0]  = fld_b;
                rd2_d[2:0]  = fld_a;
                ctl_d[C_IS] = 1'b1;
                ctl_d[C_MW] = 1'b1;
            end
            7'b0000000, 7'b0000001: begin
                rd1_d[2:0]  = fld_a;
                wr_d[2:0]   = fld_a;
                ctl_d[C_WR] = 1'b1;
                ctl_d[C_IS] = 1'b1;
                ctl_d[C_ML] = ~op[0];
                ctl_d[C_MH] = op[0];
            end
            7'b0000010, 7'b0000011: begin
                wr_d[2:0]   = fld_a;
                ctl_d[C_WR] = 1'b1;
                ctl_d[C_CL] = ~op[0];
                ctl_d[C_ST] = op[0];
            end
            7'b0000100, 7'b0000101: begin
                rd1_d[2:0]  = fld_b;
                wr_d[2:0]   = fld_a;
                ctl_d[C_WR] = 1'b1;
                ctl_d[C_IS] = 1'b1;
                ctl_d[C_SL] = ~op[0];
                ctl_d[C_SR] = op[0];
            end
            // 001S ooo is the immediate form, 011S ooo the register form
            7'b0?1????: begin
                if (op[2:0] >= 3'd1 && op[2:0] <= 3'd5) begin
                    alu_d       = op[2:0];
                    rd1_d[2:0]  = fld_b;
                    wr_d[2:0]   = fld_a;
                    ctl_d[C_WR] = 1'b1;
                    ctl_d[C_AL] = 1'b1;
                    ctl_d[C_FL] = op[3];
                    ctl_d[C_IS] = ~op[5];
                    if (op[5]) begin
                        rd2_d[2:0] = fld_c;
                    end
                end else if (op == 7'b0110110) begin
                    alu_d       = 3'b110;
                    rd1_d[2:0]  = fld_b;
                    rd2_d[2:0]  = fld_c;
                    wr_d[2:0]   = fld_a;
                    ctl_d[C_WR] = 1'b1;
                    ctl_d[C_AL] = 1'b1;
                    ctl_d[C_FL] = 1'b1;
                end else begin
                    illegal_d = 1'b1;
                end
            end
            7'b1100001: bcond_d = 1'b1;
            7'b1100100, OP_HALT: begin
            end
            default: illegal_d = 1'b1;
        endcase
    end

    assign in_ready = (state_q == ST_RUN) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        if (state_q == ST_RUN && accept && op == OP_HALT) begin
            state_d = ST_HALTED;
        end else if (state_q == ST_HALTED && HALT_STICKY == 0 && resume) begin
            state_d = ST_RUN;
        end
    end

    // A new word may load in the same cycle the old one leaves
    always_comb begin
        out_valid_d = out_valid_q;
        if (accept) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            out_valid_q <= 1'b0;
            rd1_q       <= '0;
            rd2_q       <= '0;
            wr_q        <= '0;
            alu_q       <= '0;
            imm_q       <= '0;
            ctl_q       <= '0;
            cond_q      <= '0;
            bcond_q     <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            if (accept) begin
                rd1_q     <= rd1_d;
                rd2_q     <= rd2_d;
                wr_q      <= wr_d;
                alu_q     <= alu_d;
                imm_q     <= imm_d;
                ctl_q     <= ctl_d;
                cond_q    <= cond_d;
                bcond_q   <= bcond_d;
                illegal_q <= illegal_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign rd_addr1  = rd1_q;
    assign rd_addr2  = rd2_q;
    assign wr_addr   = wr_q;
    assign alu_op    = alu_q;
    assign imm       = imm_q;
    assign ctl       = ctl_q;
    assign cond      = cond_q;
    assign is_bcond  = bcond_q;
    assign illegal   = illegal_q;
    assign halted    = (state_q == ST_HALTED);

endmodule
